// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the sequential RV32I ALU and its decoder.
package alu_pkg;
  typedef enum logic [1:0] {LW_SW = 2'b00, BEQ = 2'b01, R_TYPE = 2'b10, I_TYPE = 2'b11} alu_op_e;
  typedef enum logic [3:0] {
    AND = 4'b0000, OR = 4'b0001, ADD = 4'b0010, XOR = 4'b0011,
    SLL = 4'b0100, SRL = 4'b0101, SUB = 4'b0110, SRA = 4'b0111,
    SLT = 4'b1000, SLTU = 4'b1001, ILLEGAL = 4'b1111
  } alu_ctrl_e;
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} state_e;
endpackage

// File: rtl/alu_seq_unit_if.sv
// alu_seq_unit_if: request/response handshake bundle of the sequential ALU.
interface alu_seq_unit_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic            instr_30;
  logic [2:0]      instr_14_12;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [3:0]      alu_ctrl;
  logic            illegal;
  modport slave (input in_valid, alu_op, instr_30, instr_14_12, op_a, op_b, out_ready,
                 output in_ready, out_valid, result, zero, alu_ctrl, illegal);
  modport master (output in_valid, alu_op, instr_30, instr_14_12, op_a, op_b, out_ready,
                  input in_ready, out_valid, result, zero, alu_ctrl, illegal);
endinterface

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp plus funct7[5]/funct3 onto an RV32I operation code.
module alu_decoder
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic       instr_30,
  input  logic [2:0] funct3,
  output alu_ctrl_e  alu_ctrl
);
  logic [3:0] key;
  alu_ctrl_e  r_ctrl;
  always_comb begin
    // I-type only honours bit 30 for the shift encodings; elsewhere it is immediate data
    key = {(alu_op == I_TYPE) ? (instr_30 && funct3[1:0] == 2'b01) : instr_30, funct3};
    r_ctrl = ILLEGAL;
    case (key)
      4'b0000: r_ctrl = ADD;
      4'b1000: r_ctrl = SUB;
      4'b0001: r_ctrl = SLL;
      4'b0010: r_ctrl = SLT;
      4'b0011: r_ctrl = SLTU;
      4'b0100: r_ctrl = XOR;
      4'b0101: r_ctrl = SRL;
      4'b1101: r_ctrl = SRA;
      4'b0110: r_ctrl = OR;
      4'b0111: r_ctrl = AND;
      default: r_ctrl = ILLEGAL;
    endcase
    alu_ctrl = (alu_op == LW_SW) ? ADD :
               (alu_op == BEQ) ? SUB :
               (alu_op == I_TYPE && funct3 == 3'b000) ? ADD : r_ctrl;
  end
endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: handshaked RV32I ALU with optional one-bit-per-cycle shifter.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int SERIAL_SHIFT = 1
) (
  input logic           clk,
  input logic           rst,
  alu_seq_unit_if.slave bus
);
  localparam int SHAMT_W = $clog2(XLEN);
  state_e               state_q, state_d;
  alu_ctrl_e            ctrl_q, ctrl_d, dec;
  logic [XLEN-1:0]      res_q, res_d, alu_y, step;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d, shamt;
  logic                 zero_q, zero_d, ill_q, ill_d, accept, is_shift;
  alu_decoder u_dec (
    .alu_op   (bus.alu_op),
    .instr_30 (bus.instr_30),
    .funct3   (bus.instr_14_12),
    .alu_ctrl (dec)
  );
  assign bus.in_ready  = state_q == IDLE || (state_q == DONE && bus.out_ready);
  assign bus.out_valid = state_q == DONE;
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.alu_ctrl  = ctrl_q;
  assign bus.illegal   = ill_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign shamt         = bus.op_b[SHAMT_W-1:0];
  assign is_shift      = dec inside {SLL, SRL, SRA};
  always_comb begin
    alu_y = '0;
    case (dec)
      AND:     alu_y = bus.op_a & bus.op_b;
      OR:      alu_y = bus.op_a | bus.op_b;
      ADD:     alu_y = bus.op_a + bus.op_b;
      XOR:     alu_y = bus.op_a ^ bus.op_b;
      SUB:     alu_y = bus.op_a - bus.op_b;
      SLL:     alu_y = bus.op_a << shamt;
      SRL:     alu_y = bus.op_a >> shamt;
      SRA:     alu_y = XLEN'($signed(bus.op_a) >>> shamt);
      SLT:     alu_y = {{(XLEN-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
      SLTU:    alu_y = {{(XLEN-1){1'b0}}, bus.op_a < bus.op_b};
      default: alu_y = '0;
    endcase
  end
  always_comb begin
    step    = (ctrl_q == SLL) ? res_q << 1 :
              (ctrl_q == SRA) ? {res_q[XLEN-1], res_q[XLEN-1:1]} : res_q >> 1;
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ctrl_d  = ctrl_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    if (state_q == SHIFT) begin
      res_d = step;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == SHAMT_W'(1)) begin
        state_d = DONE;
        zero_d  = step == '0;
      end
    end else if (accept) begin
      ctrl_d = dec;
      ill_d  = dec == ILLEGAL;
      if (SERIAL_SHIFT != 0 && is_shift && shamt != '0) begin
        state_d = SHIFT;
        res_d   = bus.op_a;
        cnt_d   = shamt;
        zero_d  = 1'b0;
      end else begin
        state_d = DONE;
        res_d   = alu_y;
        zero_d  = alu_y == '0;
      end
    end else if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ctrl_q  <= AND;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ctrl_q  <= ctrl_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: vector table, corner sequences and randomized model checks.
module tb_alu_seq_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  always #5 clk = ~clk;
  alu_seq_unit_if #(.XLEN(32)) bus ();
  alu_seq_unit #(.XLEN(32), .SERIAL_SHIFT(1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  typedef struct {
    string       nm;
    logic [1:0]  op;
    logic        i30;
    logic [2:0]  f3;
    logic [31:0] a, b, er;
    logic [3:0]  ec;
    logic        ei;
    int          el;
  } vec_t;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [3:0] m_ctrl(input logic [1:0] op, input logic i30, input logic [2:0] f3);
    logic [3:0] key;
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    key = {i30, f3};
    if (op == 2'b11) begin
      if (f3 == 3'b000) return 4'b0010;
      if (f3 == 3'b001) return i30 ? 4'b1111 : 4'b0100;
      if (f3 == 3'b101) return i30 ? 4'b0111 : 4'b0101;
      key = {1'b0, f3};
    end
    case (key)
      4'b0000: return 4'b0010;
      4'b1000: return 4'b0110;
      4'b0001: return 4'b0100;
      4'b0010: return 4'b1000;
      4'b0011: return 4'b1001;
      4'b0100: return 4'b0011;
      4'b0101: return 4'b0101;
      4'b1101: return 4'b0111;
      4'b0110: return 4'b0001;
      4'b0111: return 4'b0000;
      default: return 4'b1111;
    endcase
  endfunction
  function automatic logic [31:0] m_exec(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint unsigned p2 = 64'd1 << b[4:0];
    logic [31:0] bias = 32'h8000_0000;
    logic [31:0] fill = ~(32'hffff_ffff >> b[4:0]);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return 32'(longint'(a) + longint'(b));
      4'b0011: return a ^ b;
      4'b0100: return 32'(longint'(a) * p2);
      4'b0101: return 32'(longint'(a) / p2);
      4'b0110: return 32'(longint'(a) + 64'h1_0000_0000 - longint'(b));
      4'b0111: return 32'(longint'(a) / p2) | (a[31] ? fill : 32'h0);
      4'b1000: return {31'h0, (a ^ bias) < (b ^ bias)};
      4'b1001: return {31'h0, a < b};
      default: return 32'h0;
    endcase
  endfunction
  task automatic drive(input logic [1:0] op, input logic i30, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.alu_op = op;
    bus.instr_30 = i30;
    bus.instr_14_12 = f3;
    bus.op_a = a;
    bus.op_b = b;
  endtask
  task automatic run_op(input string nm, input logic [1:0] op, input logic i30, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                        input logic [3:0] ec, input logic ei, input int el);
    int w = 0;
    int lat = 1;
    drive(op, i30, f3, a, b);
    while (!bus.in_ready && w < 50) begin
      tick();
      w++;
    end
    chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.op_a = $urandom;
    bus.op_b = $urandom;
    while (!bus.out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(el));
    chk({nm, "_result"}, bus.result, er);
    chk({nm, "_zero"}, 32'(bus.zero), 32'(er == 32'h0));
    chk({nm, "_ctrl"}, 32'(bus.alu_ctrl), 32'(ec));
    chk({nm, "_illegal"}, 32'(bus.illegal), 32'(ei));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask
  vec_t vt[$];
  logic [31:0] sb[$];
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive(2'b00, 1'b0, 3'b000, 32'h0, 32'h0);
    bus.in_valid = 1'b0;
    vt = '{
      '{"r_add",  2'b10, 1'b0, 3'b000, 32'h8000_0000, 32'h1, 32'h8000_0001, 4'b0010, 1'b0, 1},
      '{"r_sub",  2'b10, 1'b1, 3'b000, 32'h8000_0000, 32'h1, 32'h7fff_ffff, 4'b0110, 1'b0, 1},
      '{"r_sll",  2'b10, 1'b0, 3'b001, 32'h8000_0000, 32'h1, 32'h0000_0000, 4'b0100, 1'b0, 2},
      '{"r_slt",  2'b10, 1'b0, 3'b010, 32'h8000_0000, 32'h1, 32'h0000_0001, 4'b1000, 1'b0, 1},
      '{"r_sltu", 2'b10, 1'b0, 3'b011, 32'h8000_0000, 32'h1, 32'h0000_0000, 4'b1001, 1'b0, 1},
      '{"r_xor",  2'b10, 1'b0, 3'b100, 32'h8000_0000, 32'h1, 32'h8000_0001, 4'b0011, 1'b0, 1},
      '{"r_srl",  2'b10, 1'b0, 3'b101, 32'h8000_0000, 32'h1, 32'h4000_0000, 4'b0101, 1'b0, 2},
      '{"r_sra",  2'b10, 1'b1, 3'b101, 32'h8000_0000, 32'h1, 32'hc000_0000, 4'b0111, 1'b0, 2},
      '{"r_or",   2'b10, 1'b0, 3'b110, 32'h8000_0000, 32'h1, 32'h8000_0001, 4'b0001, 1'b0, 1},
      '{"r_and",  2'b10, 1'b0, 3'b111, 32'h8000_0000, 32'h1, 32'h0000_0000, 4'b0000, 1'b0, 1},
      '{"r_ill",  2'b10, 1'b1, 3'b111, 32'h8000_0000, 32'h1, 32'h0000_0000, 4'b1111, 1'b1, 1},
      '{"beq",    2'b01, 1'b0, 3'b000, 32'd42,        32'd42, 32'h0,       4'b0110, 1'b0, 1},
      '{"i_sllx", 2'b11, 1'b1, 3'b001, 32'h1,         32'h3, 32'h0,        4'b1111, 1'b1, 1},
      '{"i_add",  2'b11, 1'b1, 3'b000, 32'd3,         32'd4, 32'd7,        4'b0010, 1'b0, 1},
      '{"sll31",  2'b10, 1'b0, 3'b001, 32'h1,         32'd31, 32'h8000_0000, 4'b0100, 1'b0, 32},
      '{"sll0",   2'b10, 1'b0, 3'b001, 32'h5,         32'h0, 32'h5,        4'b0100, 1'b0, 1},
      '{"lw_add", 2'b00, 1'b1, 3'b111, 32'hffff_ffff, 32'h1, 32'h0,        4'b0010, 1'b0, 1}
    };
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
    chk("rst_ctrl", 32'(bus.alu_ctrl), 32'd0);
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    foreach (vt[i])
      run_op(vt[i].nm, vt[i].op, vt[i].i30, vt[i].f3, vt[i].a, vt[i].b, vt[i].er, vt[i].ec, vt[i].ei, vt[i].el);
    // reset arriving in the middle of a serial shift
    drive(2'b10, 1'b0, 3'b101, 32'hffff_ffff, 32'd20);
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    chk("midshift_busy", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_result", bus.result, 32'h0);
    tick();
    rst = 1'b0;
    run_op("post_rst_add", 2'b00, 1'b0, 3'b000, 32'd1, 32'd1, 32'd2, 4'b0010, 1'b0, 1);
    // backpressure, then same-cycle retire and accept
    drive(2'b00, 1'b0, 3'b000, 32'd5, 32'd7);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_result", bus.result, 32'd12);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    drive(2'b00, 1'b0, 3'b000, 32'd2, 32'd3);
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_next_result", bus.result, 32'd5);
    tick();
    // back-to-back ADD stream with a scoreboard
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a = $urandom, b = $urandom;
      drive(2'b00, 1'($urandom), 3'($urandom), a, b);
      if (bus.in_ready) sb.push_back(m_exec(4'b0010, a, b));
      tick();
      chk("b2b_valid", 32'(bus.out_valid), 32'd1);
      if (bus.out_valid && sb.size() > 0) chk("b2b_result", bus.result, sb.pop_front());
    end
    bus.in_valid = 1'b0;
    chk("b2b_leftover", 32'(sb.size()), 32'd0);
    tick();
    bus.out_ready = 1'b0;
    // randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op = 2'($urandom);
      logic        i30 = 1'($urandom);
      logic [2:0]  f3 = 3'($urandom);
      logic [31:0] a = $urandom, b = $urandom;
      logic [3:0]  c = m_ctrl(op, i30, f3);
      int          el = (c == 4'b0100 || c == 4'b0101 || c == 4'b0111) ? 1 + int'(b[4:0]) : 1;
      run_op("rand", op, i30, f3, a, b, m_exec(c, a, b), c, c == 4'b1111, el);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
